// File: rtl/cntr8_pkg.sv
// -----------------------------------------------------------------------------
// cntr8_pkg
// Shared definitions for the 8-bit counter controller and the counter's
// output-logic stage.
//   - cntr_state_e : counter state encodings (IDLE..DEC2), 3 bits
//   - cntr_op_e    : command op codes (CLEAR/LOAD/INC/DEC), 2 bits
//   - exec_state_e : executor FSM states (FREE/RUN)
//   - step_count / step_wraps / next_phase : single-step helpers
// -----------------------------------------------------------------------------
package cntr8_pkg;

    localparam int CNT_W = 8;
    localparam int OP_W  = 2;
    localparam int ST_W  = 3;

    // Encodings are fixed: the downstream output-logic stage decodes them.
    // 3'b110 and 3'b111 are never driven.
    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_INC  = 3'b010,
        ST_INC2 = 3'b011,
        ST_DEC  = 3'b100,
        ST_DEC2 = 3'b101
    } cntr_state_e;

    typedef enum logic [OP_W-1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_INC   = 2'b10,
        OP_DEC   = 2'b11
    } cntr_op_e;

    typedef enum logic {
        EX_FREE = 1'b0,
        EX_RUN  = 1'b1
    } exec_state_e;

    // One counting step, modulo 2^CNT_W.
    function automatic logic [CNT_W-1:0] step_count(input logic [CNT_W-1:0] c,
                                                    input logic             dec);
        return dec ? (c - CNT_W'(1)) : (c + CNT_W'(1));
    endfunction

    // True when the step taken from value c crosses the modulus boundary.
    function automatic logic step_wraps(input logic [CNT_W-1:0] c,
                                        input logic             dec);
        return dec ? (c == '0) : (c == '1);
    endfunction

    // Phase alternation within a run: INC,INC2,INC,... or DEC,DEC2,DEC,...
    function automatic cntr_state_e next_phase(input cntr_state_e s,
                                               input logic        dec);
        if (dec)
            return (s == ST_DEC) ? ST_DEC2 : ST_DEC;
        else
            return (s == ST_INC) ? ST_INC2 : ST_INC;
    endfunction

endpackage

// File: rtl/cntr8_ctrl_if.sv
// -----------------------------------------------------------------------------
// cntr8_ctrl_if
// Command channel into the counter controller (valid/ready handshake).
//   cmd_valid : command present            (master -> slave)
//   cmd_ready : controller can accept      (slave  -> master)
//   cmd_op    : 00 CLEAR, 01 LOAD, 10 INC, 11 DEC
//   cmd_data  : load value (LOAD only)
//   cmd_len   : step count for INC/DEC, 0 encodes 2^LEN_W
// Modports: master (command source), slave (controller).
// -----------------------------------------------------------------------------
interface cntr8_ctrl_if
    import cntr8_pkg::*;
#(
    parameter int LEN_W = 4
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [CNT_W-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_len,
        output cmd_ready
    );

endinterface

// File: rtl/cntr8_ctrl_cmd_fifo2.sv
// -----------------------------------------------------------------------------
// cmd_fifo2
// Small synchronous FIFO holding packed {op, data, len} commands.
//   clk, reset : clock, asynchronous active-high reset (flushes contents)
//   push       : write wr_data at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   wr_data    : entry to write
//   rd_data    : head entry (valid while !empty)
//   full/empty : occupancy flags, derived from the registered level
// -----------------------------------------------------------------------------
module cmd_fifo2 #(
    parameter int DEPTH = 2,
    parameter int W     = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;

    logic do_push;
    logic do_pop;

    // A push is refused whenever the queue is full, even if the head is
    // popped on the same edge; the source sees cmd_ready low that cycle.
    assign do_push = push && !full;
    assign do_pop  = pop  && !empty;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : (p + PTR_W'(1));
    endfunction

    // Storage needs no reset: entries are only observed while level > 0.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/cntr8_ctrl.sv
// -----------------------------------------------------------------------------
// cntr8_ctrl
// Command-driven controller for the 8-bit counter datapath. Commands arrive
// over a valid/ready channel, are queued in a 2-entry FIFO and executed one
// step per clock, producing the registered state/d_in pair for the counter's
// output-logic stage. A shadow copy of the count drives wrap detection and
// the idle re-hold (state LOAD with d_in = count).
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   cmd    : command channel (slave modport of cntr8_ctrl_if)
//   state  : registered counter state (cntr_state_e encoding)
//   d_in   : registered load value presented with state
//   count  : shadow count, equal to the downstream counter value
//   wrap   : one-cycle pulse on the step that wraps FF->00 or 00->FF
//   busy   : a command step is presented or the queue is non-empty
// -----------------------------------------------------------------------------
module cntr8_ctrl
    import cntr8_pkg::*;
#(
    parameter int DEPTH = 2,    // fixed at 2 for this revision
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    cntr8_ctrl_if.slave      cmd,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] d_in,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             busy
);

    localparam int ENT_W = OP_W + CNT_W + LEN_W;

    // ---------------------------------------------------------------
    // Command queue
    // ---------------------------------------------------------------
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ENT_W-1:0] fifo_wr;
    logic [ENT_W-1:0] fifo_head;

    cntr_op_e         head_op;
    logic [CNT_W-1:0] head_data;
    logic [LEN_W-1:0] head_len;

    assign fifo_push = cmd.cmd_valid;
    assign fifo_wr   = {cmd.cmd_op, cmd.cmd_data, cmd.cmd_len};

    assign head_op   = cntr_op_e'(fifo_head[ENT_W-1 -: OP_W]);
    assign head_data = fifo_head[LEN_W +: CNT_W];
    assign head_len  = fifo_head[LEN_W-1:0];

    cmd_fifo2 #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (fifo_wr),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---------------------------------------------------------------
    // Executor registers
    // ---------------------------------------------------------------
    exec_state_e      ex_q,    ex_d;
    logic [LEN_W-1:0] rem_q,   rem_d;     // steps still to run after this one
    logic             dec_q,   dec_d;     // current run counts down
    cntr_state_e      state_q, state_d;
    logic [CNT_W-1:0] d_in_q,  d_in_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             wrap_q,  wrap_d;
    logic             busy_q,  busy_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= EX_FREE;
            rem_q   <= '0;
            dec_q   <= 1'b0;
            state_q <= ST_IDLE;
            d_in_q  <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ex_q    <= ex_d;
            rem_q   <= rem_d;
            dec_q   <= dec_d;
            state_q <= state_d;
            d_in_q  <= d_in_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic.
    // The first step of a popped command is registered on the pop edge itself,
    // and the executor returns to FREE on the edge of the last step, so a
    // queued command follows with no hold cycle in between.
    always_comb begin
        ex_d     = ex_q;
        rem_d    = rem_q;
        dec_d    = dec_q;
        state_d  = state_q;
        d_in_d   = d_in_q;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        fifo_pop = 1'b0;

        case (ex_q)
            EX_RUN: begin
                state_d = next_phase(state_q, dec_q);
                cnt_d   = step_count(cnt_q, dec_q);
                wrap_d  = step_wraps(cnt_q, dec_q);
                rem_d   = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1))
                    ex_d = EX_FREE;
            end

            EX_FREE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    case (head_op)
                        OP_CLEAR: begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                        OP_LOAD: begin
                            state_d = ST_LOAD;
                            d_in_d  = head_data;
                            cnt_d   = head_data;
                        end
                        OP_INC, OP_DEC: begin
                            dec_d   = (head_op == OP_DEC);
                            state_d = (head_op == OP_DEC) ? ST_DEC : ST_INC;
                            cnt_d   = step_count(cnt_q, head_op == OP_DEC);
                            wrap_d  = step_wraps(cnt_q, head_op == OP_DEC);
                            // len 0 encodes 2^LEN_W; the modular subtract
                            // yields the correct remaining count for it too.
                            rem_d   = head_len - LEN_W'(1);
                            if (rem_d != '0)
                                ex_d = EX_RUN;
                        end
                    endcase
                end else begin
                    // Idle re-hold keeps the downstream value unchanged.
                    state_d = ST_LOAD;
                    d_in_d  = cnt_q;
                end
            end
        endcase

        // Non-empty queue while FREE always pops, so this covers both a step
        // being presented and entries remaining after the edge.
        busy_d = (ex_q == EX_RUN) || !fifo_empty || (fifo_push && !fifo_full);
    end

    // Output logic
    always_comb begin
        cmd.cmd_ready = !fifo_full;
        state         = state_q;
        d_in          = d_in_q;
        count         = cnt_q;
        wrap          = wrap_q;
        busy          = busy_q;
    end

endmodule

// File: tb/tb_cntr8_ctrl.sv
module tb_cntr8_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] state;
    logic [7:0] d_in;
    logic [7:0] count;
    logic       wrap;
    logic       busy;

    int passed;
    int total;

    cntr8_ctrl_if #(.LEN_W(4)) cmd_if ();

    cntr8_ctrl #(
        .DEPTH (2),
        .LEN_W (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cmd_if),
        .state (state),
        .d_in  (d_in),
        .count (count),
        .wrap  (wrap),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [7:0] data, input logic [3:0] len);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        cmd_if.cmd_len   = len;
    endtask

    task automatic idle_in();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_data  = 8'h00;
        cmd_if.cmd_len   = 4'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_in();
        tick();
        tick();
        total++; if (state !== 3'b000) $display("FAIL reset_state: got %b want 000", state); else passed++;
        total++; if (count !== 8'h00) $display("FAIL reset_count: got %h want 00", count); else passed++;
        total++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_if.cmd_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (d_in !== 8'h00) $display("FAIL reset_d_in: got %h want 00", d_in); else passed++;
        reset = 1'b0;
        tick();
        total++; if (state !== 3'b001) $display("FAIL release_state: got %b want 001", state); else passed++;
        total++; if (d_in !== 8'h00) $display("FAIL release_d_in: got %h want 00", d_in); else passed++;
    endtask

    task automatic test_load_inc();
        logic [2:0] es [5];
        logic [7:0] ec [5];
        logic [7:0] ed [2];
        es = '{3'b001, 3'b010, 3'b011, 3'b010, 3'b001};
        ec = '{8'h3C, 8'h3D, 8'h3E, 8'h3F, 8'h3F};
        ed = '{8'h3C, 8'h3F};
        drive(2'b01, 8'h3C, 4'd0);
        tick();
        drive(2'b10, 8'h00, 4'd3);
        tick();
        idle_in();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            total++; if (state !== es[i]) $display("FAIL load_inc_state[%0d]: got %b want %b", i, state, es[i]); else passed++;
            total++; if (count !== ec[i]) $display("FAIL load_inc_count[%0d]: got %h want %h", i, count, ec[i]); else passed++;
            if (i == 0) begin
                total++; if (d_in !== ed[0]) $display("FAIL load_inc_d_in_load: got %h want %h", d_in, ed[0]); else passed++;
            end
            if (i == 4) begin
                total++; if (d_in !== ed[1]) $display("FAIL load_inc_d_in_hold: got %h want %h", d_in, ed[1]); else passed++;
                total++; if (busy !== 1'b0) $display("FAIL load_inc_busy_hold: got %b want 0", busy); else passed++;
            end
        end
    endtask

    task automatic test_inc_wrap();
        logic [2:0] es [5];
        logic [7:0] ec [5];
        logic       ew [5];
        es = '{3'b001, 3'b010, 3'b011, 3'b010, 3'b001};
        ec = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h01};
        ew = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        drive(2'b01, 8'hFE, 4'd0);
        tick();
        drive(2'b10, 8'h00, 4'd3);
        tick();
        idle_in();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            total++; if (state !== es[i]) $display("FAIL inc_wrap_state[%0d]: got %b want %b", i, state, es[i]); else passed++;
            total++; if (count !== ec[i]) $display("FAIL inc_wrap_count[%0d]: got %h want %h", i, count, ec[i]); else passed++;
            total++; if (wrap !== ew[i]) $display("FAIL inc_wrap_wrap[%0d]: got %b want %b", i, wrap, ew[i]); else passed++;
        end
    endtask

    task automatic test_dec_wrap();
        logic [2:0] es [3];
        logic [7:0] ec [3];
        logic       ew [3];
        es = '{3'b100, 3'b101, 3'b001};
        ec = '{8'h00, 8'hFF, 8'hFF};
        ew = '{1'b0, 1'b1, 1'b0};
        drive(2'b11, 8'h00, 4'd2);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (state !== es[i]) $display("FAIL dec_wrap_state[%0d]: got %b want %b", i, state, es[i]); else passed++;
            total++; if (count !== ec[i]) $display("FAIL dec_wrap_count[%0d]: got %h want %h", i, count, ec[i]); else passed++;
            total++; if (wrap !== ew[i]) $display("FAIL dec_wrap_wrap[%0d]: got %b want %b", i, wrap, ew[i]); else passed++;
        end
        total++; if (d_in !== 8'hFF) $display("FAIL dec_wrap_hold_d_in: got %h want FF", d_in); else passed++;
    endtask

    // Starts from count FF: INC L=0 (16 steps), LOAD 55, CLEAR queued behind it,
    // then an INC L=1 held valid while the queue is full.
    task automatic test_back_to_back();
        drive(2'b10, 8'h00, 4'd0);
        tick();
        drive(2'b01, 8'h55, 4'd0);
        tick();
        // step 1: FF -> 00
        total++; if (state !== 3'b010) $display("FAIL b2b_step1_state: got %b want 010", state); else passed++;
        total++; if (count !== 8'h00) $display("FAIL b2b_step1_count: got %h want 00", count); else passed++;
        total++; if (wrap !== 1'b1) $display("FAIL b2b_step1_wrap: got %b want 1", wrap); else passed++;
        total++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL b2b_ready_one_entry: got %b want 1", cmd_if.cmd_ready); else passed++;
        drive(2'b00, 8'h00, 4'd0);
        tick();
        // step 2, CLEAR accepted: queue now holds LOAD and CLEAR
        total++; if (state !== 3'b011) $display("FAIL b2b_step2_state: got %b want 011", state); else passed++;
        total++; if (count !== 8'h01) $display("FAIL b2b_step2_count: got %h want 01", count); else passed++;
        total++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL b2b_ready_full: got %b want 0", cmd_if.cmd_ready); else passed++;
        drive(2'b10, 8'h00, 4'd1);
        for (int k = 3; k <= 16; k++) begin
            logic [2:0] exp_st;
            logic [7:0] exp_cnt;
            exp_st  = (k % 2 == 1) ? 3'b010 : 3'b011;
            exp_cnt = 8'(k - 1);
            tick();
            total++; if (state !== exp_st) $display("FAIL b2b_step%0d_state: got %b want %b", k, state, exp_st); else passed++;
            total++; if (count !== exp_cnt) $display("FAIL b2b_step%0d_count: got %h want %h", k, count, exp_cnt); else passed++;
            total++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL b2b_step%0d_ready: got %b want 0", k, cmd_if.cmd_ready); else passed++;
            total++; if (wrap !== 1'b0) $display("FAIL b2b_step%0d_wrap: got %b want 0", k, wrap); else passed++;
        end
        tick();
        // LOAD popped while full: held INC L=1 must not have been pushed
        total++; if (state !== 3'b001) $display("FAIL b2b_load_state: got %b want 001", state); else passed++;
        total++; if (d_in !== 8'h55) $display("FAIL b2b_load_d_in: got %h want 55", d_in); else passed++;
        total++; if (count !== 8'h55) $display("FAIL b2b_load_count: got %h want 55", count); else passed++;
        total++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL b2b_ready_after_pop: got %b want 1", cmd_if.cmd_ready); else passed++;
        tick();
        idle_in();
        total++; if (state !== 3'b000) $display("FAIL b2b_clear_state: got %b want 000", state); else passed++;
        total++; if (count !== 8'h00) $display("FAIL b2b_clear_count: got %h want 00", count); else passed++;
        tick();
        total++; if (state !== 3'b010) $display("FAIL b2b_late_inc_state: got %b want 010", state); else passed++;
        total++; if (count !== 8'h01) $display("FAIL b2b_late_inc_count: got %h want 01", count); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL b2b_late_inc_busy: got %b want 1", busy); else passed++;
        tick();
        total++; if (state !== 3'b001) $display("FAIL b2b_hold_state: got %b want 001", state); else passed++;
        total++; if (d_in !== 8'h01) $display("FAIL b2b_hold_d_in: got %h want 01", d_in); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL b2b_hold_busy: got %b want 0", busy); else passed++;
    endtask

    // Starts from count 01.
    task automatic test_async_reset();
        drive(2'b10, 8'h00, 4'd5);
        tick();
        drive(2'b01, 8'h77, 4'd0);
        tick();
        idle_in();
        total++; if (count !== 8'h02) $display("FAIL rst_mid_step1_count: got %h want 02", count); else passed++;
        tick();
        total++; if (state !== 3'b011) $display("FAIL rst_mid_step2_state: got %b want 011", state); else passed++;
        total++; if (count !== 8'h03) $display("FAIL rst_mid_step2_count: got %h want 03", count); else passed++;
        reset = 1'b1;
        #2;
        total++; if (state !== 3'b000) $display("FAIL rst_async_state: got %b want 000", state); else passed++;
        total++; if (count !== 8'h00) $display("FAIL rst_async_count: got %h want 00", count); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy); else passed++;
        total++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL rst_async_ready: got %b want 1", cmd_if.cmd_ready); else passed++;
        tick();
        reset = 1'b0;
        tick();
        total++; if (state !== 3'b001) $display("FAIL rst_release_state: got %b want 001", state); else passed++;
        total++; if (d_in !== 8'h00) $display("FAIL rst_release_d_in: got %h want 00", d_in); else passed++;
        tick();
        total++; if (state !== 3'b001) $display("FAIL rst_flushed_state: got %b want 001", state); else passed++;
        total++; if (count !== 8'h00) $display("FAIL rst_flushed_count: got %h want 00", count); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_flushed_busy: got %b want 0", busy); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        idle_in();
        test_reset();
        test_load_inc();
        test_inc_wrap();
        test_dec_wrap();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
